// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (pipeline) has priority, port 1 (loader/debug)
// is protected from starvation and may lock the memory for bursts.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_err,
  output logic        p1_err,
  output logic        dmem,
  output logic [31:0] data_w,
  output logic [31:0] addr,
  input  logic [31:0] data_o
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, LOCK1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [31:0]      p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic             p0_err_q, p0_err_d, p1_err_q, p1_err_d;

  logic        g0, g1, gnt_any, oob0, oob1, sel_oob, sel_we, in_range;
  logic [31:0] sel_addr, sel_wdata;

  assign oob0 = ({1'b0, p0_addr} >= DEPTH);
  assign oob1 = ({1'b0, p1_addr} >= DEPTH);

  // Grant: LOCK1 or a saturated starve counter hands port 1 priority; reset blocks all access
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (p1_req && ((state_q == LOCK1) || (starve_cnt_q == STARVE_LIM) || !p0_req)) begin
        g1 = 1'b1;
      end else begin
        g0 = p0_req;
      end
    end
  end

  assign gnt_any   = g0 | g1;
  assign sel_we    = g1 ? p1_we    : p0_we;
  assign sel_addr  = g1 ? p1_addr  : p0_addr;
  assign sel_wdata = g1 ? p1_wdata : p0_wdata;
  assign sel_oob   = g1 ? oob1     : oob0;
  assign in_range  = gnt_any && !sel_oob;

  // Memory side idles as a read of word 0 so nothing is ever written by accident
  assign dmem   = !(in_range && sel_we);
  assign addr   = in_range ? sel_addr  : 32'd0;
  assign data_w = in_range ? sel_wdata : 32'd0;
  assign p0_gnt = g0;
  assign p1_gnt = g1;

  always_comb begin
    state_d      = IDLE;
    starve_cnt_d = starve_cnt_q;
    if (g1) begin
      state_d = p1_lock ? LOCK1 : OWN1;
    end else if (g0) begin
      state_d = OWN0;
    end
    if (g1) begin
      starve_cnt_d = '0;
    end else if (p1_req && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Read response path: out-of-range reads return zero, rdata holds between reads
  always_comb begin
    p0_rvalid_d = g0 && !p0_we;
    p1_rvalid_d = g1 && !p1_we;
    p0_err_d    = g0 && oob0;
    p1_err_d    = g1 && oob1;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (p0_rvalid_d) p0_rdata_d = oob0 ? 32'd0 : data_o;
    if (p1_rvalid_d) p1_rdata_d = oob1 ? 32'd0 : data_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= 32'd0;
      p1_rdata_q   <= 32'd0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a 32-word behavioural memory attached.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p1_req, p0_we, p1_we, p1_lock;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        dmem;
  logic [31:0] data_w, addr, data_o;

  logic [31:0] mem_arr [0:31];

  typedef struct {
    logic        port;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(5), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_err(p0_err), .p1_err(p1_err),
    .dmem(dmem), .data_w(data_w), .addr(addr), .data_o(data_o)
  );

  // Memory writes whenever dmem is low, reads combinationally
  always @(posedge clk) if (!dmem) mem_arr[addr[4:0]] <= data_w;
  assign data_o = mem_arr[addr[4:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    logic is0, is1;
    is0 = p0_rvalid | p0_err;
    is1 = p1_rvalid | p1_err;
    if (rst || !(is0 || is1)) return;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_resp p0v=%b p0e=%b p1v=%b p1e=%b t=%0t",
               p0_rvalid, p0_err, p1_rvalid, p1_err, $time);
      return;
    end
    e = sb_q.pop_front();
    chk("resp_both_ports", 32'(is0 & is1), 32'd0);
    chk("resp_port", 32'(is1), 32'(e.port));
    if (e.port) begin
      chk("p1_rvalid", 32'(p1_rvalid), 32'(e.rvalid));
      chk("p1_err", 32'(p1_err), 32'(e.err));
      if (e.rvalid) chk("p1_rdata", p1_rdata, e.rdata);
    end else begin
      chk("p0_rvalid", 32'(p0_rvalid), 32'(e.rvalid));
      chk("p0_err", 32'(p0_err), 32'(e.err));
      if (e.rvalid) chk("p0_rdata", p0_rdata, e.rdata);
    end
  endtask

  // One arbitration cycle: drive, check combinational side, queue expected response
  task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic lk, input logic eg0, input logic eg1, input logic [31:0] erd);
    logic        we, oob;
    logic [31:0] a, d;
    exp_t        e;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
    #1;
    chk("p0_gnt", 32'(p0_gnt), 32'(eg0));
    chk("p1_gnt", 32'(p1_gnt), 32'(eg1));
    we  = eg1 ? w1 : w0;
    a   = eg1 ? a1 : a0;
    d   = eg1 ? d1 : d0;
    oob = (a >= 32'd32);
    if (!(eg0 || eg1) || oob) begin
      chk("dmem_idle", 32'(dmem), 32'd1);
      chk("addr_idle", addr, 32'd0);
    end else begin
      chk("dmem", 32'(dmem), 32'(!we));
      chk("addr", addr, a);
      if (we) chk("data_w", data_w, d);
    end
    if (eg0 || eg1) begin
      if (!we || oob) begin
        e.port = eg1; e.rvalid = !we; e.rdata = oob ? 32'd0 : erd; e.err = oob;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd7; p0_wdata = 32'h55;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd2; p1_wdata = 32'd0; p1_lock = 1'b0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none
    #3;
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_dmem", 32'(dmem), 32'd1);
    chk("rst_addr", addr, 32'd0);
    chk("rst_data_w", data_w, 32'd0);
    chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // p0 write then readback
    cyc(1, 1, 0, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0,            0, 0, 0, 0, 0, 1, 0, 32'hAAAAAAAA);
    idle();

    // Both requesting: p0 x4, p1 on the fifth, then p0
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, (i != 4), (i == 4), 32'hAAAAAAAA);
    end
    idle();

    // Locked burst by p1 keeps p0 out
    cyc(0, 0, 0, 0, 1, 1, 3, 32'hBBBBBBBB, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 4, 32'hCCCCCCCC, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 3, 0,            1, 0, 1, 32'hBBBBBBBB);
    cyc(1, 0, 0, 0, 1, 0, 4, 0,            0, 0, 1, 32'hCCCCCCCC);
    cyc(1, 0, 3, 0, 0, 0, 0, 0,            0, 1, 0, 32'hBBBBBBBB);
    cyc(1, 0, 4, 0, 0, 0, 0, 0,            0, 1, 0, 32'hCCCCCCCC);
    // Lock exit via p1_req dropping: p0 granted in the exit cycle
    cyc(0, 0, 0, 0, 1, 1, 5, 32'h12345678, 1, 0, 1, 0);
    cyc(1, 0, 5, 0, 0, 0, 0, 0,            0, 1, 0, 32'h12345678);

    // Out-of-range accesses
    cyc(1, 1, 32, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("p0_rdata_hold", p0_rdata, 32'h12345678);
    chk("mem0_kept", mem_arr[0], 32'hAAAAAAAA);
    cyc(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'hAAAAAAAA);
    cyc(0, 0, 0, 0, 1, 0, 40, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 4,  0, 0, 0, 1, 32'hCCCCCCCC);
    idle();

    // Reset mid-cycle during a p1 read
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd3; p1_lock = 1'b0;
    #1;
    chk("abort_pre_gnt", 32'(p1_gnt), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("abort_dmem", 32'(dmem), 32'd1);
    chk("abort_addr", addr, 32'd0);
    chk("abort_p1_rdata", p1_rdata, 32'd0);
    chk("abort_p0_rdata", p0_rdata, 32'd0);
    chk("abort_flags", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    p1_req = 1'b0;

    // Quiet period after reset
    idle(); idle(); idle();
    chk("post_rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
